// File: rtl/ipv4_tx_pkt_arbiter.sv
// Packet-atomic arbiter merging the UDP and ICMP FWFT byte streams onto the IPv4 TX byte stream.
// Grants per packet (round-robin or ICMP priority), truncates and drains oversize packets.
module ipv4_tx_pkt_arbiter #(
  parameter int unsigned MAX_PKT_BYTES        = 1500,
  parameter bit          ICMP_STRICT_PRIORITY = 1'b0
) (
  input  logic        i_txmac_clk,
  input  logic        i_txmac_srst,
  input  logic [7:0]  i_udp_pkt_byte,
  input  logic        i_udp_pkt_byte_vld,
  input  logic        i_udp_pkt_last_byte,
  output logic        o_udp_pkt_byte_rd,
  input  logic [7:0]  i_icmp_pkt_byte,
  input  logic        i_icmp_pkt_byte_vld,
  input  logic        i_icmp_pkt_last_byte,
  output logic        o_icmp_pkt_byte_rd,
  output logic [7:0]  o_ipv4_pkt_byte,
  output logic        o_ipv4_pkt_byte_vld,
  output logic        o_ipv4_pkt_last_byte,
  input  logic        i_ipv4_pkt_byte_rd,
  output logic        o_pkt_len_err,
  output logic [15:0] o_udp_pkt_cnt,
  output logic [15:0] o_icmp_pkt_cnt
);

  localparam int unsigned     CntW   = $clog2(MAX_PKT_BYTES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_PKT_BYTES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGrantUdp,
    StGrantIcmp,
    StDrainUdp,
    StDrainIcmp
  } state_e;

  state_e          state_q, state_d;
  logic            last_icmp_q, last_icmp_d;
  logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
  logic            len_err_q, len_err_d;
  logic [15:0]     udp_cnt_q, udp_cnt_d;
  logic [15:0]     icmp_cnt_q, icmp_cnt_d;

  logic       sel_icmp;
  logic [7:0] src_byte;
  logic       src_vld;
  logic       src_last;
  logic       src_rd;
  logic       at_max;
  logic       grant_any;
  logic       grant_icmp;

  // Source mux is shared by the grant and drain states of each source.
  assign sel_icmp = (state_q == StGrantIcmp) || (state_q == StDrainIcmp);
  assign src_byte = sel_icmp ? i_icmp_pkt_byte : i_udp_pkt_byte;
  assign src_vld  = sel_icmp ? i_icmp_pkt_byte_vld : i_udp_pkt_byte_vld;
  assign src_last = sel_icmp ? i_icmp_pkt_last_byte : i_udp_pkt_last_byte;
  assign at_max   = (byte_cnt_q == CntMax);

  always_comb begin
    grant_any = i_udp_pkt_byte_vld | i_icmp_pkt_byte_vld;
    if (i_udp_pkt_byte_vld && i_icmp_pkt_byte_vld) begin
      grant_icmp = ICMP_STRICT_PRIORITY || !last_icmp_q;
    end else begin
      grant_icmp = i_icmp_pkt_byte_vld;
    end
  end

  always_comb begin
    state_d              = state_q;
    last_icmp_d          = last_icmp_q;
    byte_cnt_d           = byte_cnt_q;
    len_err_d            = 1'b0;
    udp_cnt_d            = udp_cnt_q;
    icmp_cnt_d           = icmp_cnt_q;
    src_rd               = 1'b0;
    o_ipv4_pkt_byte      = '0;
    o_ipv4_pkt_byte_vld  = 1'b0;
    o_ipv4_pkt_last_byte = 1'b0;

    unique case (state_q)
      StIdle: begin
        byte_cnt_d = '0;
        if (grant_any) begin
          state_d     = grant_icmp ? StGrantIcmp : StGrantUdp;
          last_icmp_d = grant_icmp;
        end
      end
      StGrantUdp, StGrantIcmp: begin
        o_ipv4_pkt_byte      = src_byte;
        o_ipv4_pkt_byte_vld  = src_vld;
        o_ipv4_pkt_last_byte = src_last | at_max;
        src_rd               = i_ipv4_pkt_byte_rd & src_vld;
        if (src_rd) begin
          byte_cnt_d = byte_cnt_q + CntW'(1);
          if (src_last || at_max) begin
            if (sel_icmp) icmp_cnt_d = icmp_cnt_q + 16'd1;
            else          udp_cnt_d  = udp_cnt_q + 16'd1;
            if (src_last) begin
              state_d = StIdle;
            end else begin
              // Truncated: the rest of the source packet is popped and discarded.
              state_d   = sel_icmp ? StDrainIcmp : StDrainUdp;
              len_err_d = 1'b1;
            end
          end
        end
      end
      StDrainUdp, StDrainIcmp: begin
        src_rd = src_vld;
        if (src_vld && src_last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_udp_pkt_byte_rd  = src_rd & ~sel_icmp;
  assign o_icmp_pkt_byte_rd = src_rd & sel_icmp;
  assign o_pkt_len_err      = len_err_q;
  assign o_udp_pkt_cnt      = udp_cnt_q;
  assign o_icmp_pkt_cnt     = icmp_cnt_q;

  always_ff @(posedge i_txmac_clk) begin
    if (i_txmac_srst) begin
      state_q     <= StIdle;
      last_icmp_q <= 1'b1;
      byte_cnt_q  <= '0;
      len_err_q   <= 1'b0;
      udp_cnt_q   <= '0;
      icmp_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_icmp_q <= last_icmp_d;
      byte_cnt_q  <= byte_cnt_d;
      len_err_q   <= len_err_d;
      udp_cnt_q   <= udp_cnt_d;
      icmp_cnt_q  <= icmp_cnt_d;
    end
  end

endmodule

// File: tb/tb_ipv4_tx_pkt_arbiter.sv
// Bench for ipv4_tx_pkt_arbiter: a round-robin and an ICMP-priority instance driven by queued
// packet sources, checked against per-source expected-output queues.
module tb_ipv4_tx_pkt_arbiter;

  localparam int Max = 1500;

  logic        clk = 1'b0;
  logic        srst;
  logic [7:0]  udp_byte  [2];
  logic [7:0]  icmp_byte [2];
  logic [7:0]  o_byte    [2];
  logic [15:0] udp_cnt   [2];
  logic [15:0] icmp_cnt  [2];
  logic [1:0]  udp_vld, udp_last, udp_rd, icmp_vld, icmp_last, icmp_rd;
  logic [1:0]  o_vld, o_last, sink_rd, len_err;

  always #5 clk = ~clk;

  ipv4_tx_pkt_arbiter #(.MAX_PKT_BYTES(Max), .ICMP_STRICT_PRIORITY(1'b0)) u_dut_rr (
    .i_txmac_clk         (clk),
    .i_txmac_srst        (srst),
    .i_udp_pkt_byte      (udp_byte[0]),
    .i_udp_pkt_byte_vld  (udp_vld[0]),
    .i_udp_pkt_last_byte (udp_last[0]),
    .o_udp_pkt_byte_rd   (udp_rd[0]),
    .i_icmp_pkt_byte     (icmp_byte[0]),
    .i_icmp_pkt_byte_vld (icmp_vld[0]),
    .i_icmp_pkt_last_byte(icmp_last[0]),
    .o_icmp_pkt_byte_rd  (icmp_rd[0]),
    .o_ipv4_pkt_byte     (o_byte[0]),
    .o_ipv4_pkt_byte_vld (o_vld[0]),
    .o_ipv4_pkt_last_byte(o_last[0]),
    .i_ipv4_pkt_byte_rd  (sink_rd[0]),
    .o_pkt_len_err       (len_err[0]),
    .o_udp_pkt_cnt       (udp_cnt[0]),
    .o_icmp_pkt_cnt      (icmp_cnt[0])
  );

  ipv4_tx_pkt_arbiter #(.MAX_PKT_BYTES(Max), .ICMP_STRICT_PRIORITY(1'b1)) u_dut_sp (
    .i_txmac_clk         (clk),
    .i_txmac_srst        (srst),
    .i_udp_pkt_byte      (udp_byte[1]),
    .i_udp_pkt_byte_vld  (udp_vld[1]),
    .i_udp_pkt_last_byte (udp_last[1]),
    .o_udp_pkt_byte_rd   (udp_rd[1]),
    .i_icmp_pkt_byte     (icmp_byte[1]),
    .i_icmp_pkt_byte_vld (icmp_vld[1]),
    .i_icmp_pkt_last_byte(icmp_last[1]),
    .o_icmp_pkt_byte_rd  (icmp_rd[1]),
    .o_ipv4_pkt_byte     (o_byte[1]),
    .o_ipv4_pkt_byte_vld (o_vld[1]),
    .o_ipv4_pkt_last_byte(o_last[1]),
    .i_ipv4_pkt_byte_rd  (sink_rd[1]),
    .o_pkt_len_err       (len_err[1]),
    .o_udp_pkt_cnt       (udp_cnt[1]),
    .o_icmp_pkt_cnt      (icmp_cnt[1])
  );

  // Index k = dut*2 + src, src 0 = UDP, 1 = ICMP. UDP bytes have bit 7 clear, ICMP bytes set.
  logic [8:0] srcq [4][$];
  logic [8:0] expq [4][$];
  int exp_drain [4];
  int got_drain [4];
  int exp_pkts  [4];
  int pops      [4];
  int exp_err   [2];
  int err_pulses[2];
  int err_hi    [2];
  logic [1:0] err_prev;
  int cur_src   [2];
  int start_src [2][$];
  int start_cyc [2][$];
  int end_cyc   [2][$];
  int cyc;
  int gap_pct;
  int sink_pct;
  int n_cmp;
  int n_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 4; k++) begin
      srcq[k].delete();
      expq[k].delete();
      exp_drain[k] = 0;
      got_drain[k] = 0;
      exp_pkts[k]  = 0;
      pops[k]      = 0;
    end
    for (int d = 0; d < 2; d++) begin
      exp_err[d]    = 0;
      err_pulses[d] = 0;
      err_hi[d]     = 0;
      cur_src[d]    = -1;
      start_src[d].delete();
      start_cyc[d].delete();
      end_cyc[d].delete();
    end
    err_prev = '0;
  endtask

  // Expected output: first min(len, Max) bytes, last flag on the final delivered byte.
  task automatic add_pkt(input int d, input int s, input int len);
    int k;
    logic [7:0] b;
    k = d * 2 + s;
    for (int i = 0; i < len; i++) begin
      b    = 8'($urandom);
      b[7] = (s == 1);
      srcq[k].push_back({(i == len - 1), b});
      if (i < Max) expq[k].push_back({(i == len - 1) || (i == Max - 1), b});
    end
    if (len > Max) begin
      exp_drain[k] += len - Max;
      exp_err[d]++;
    end
    exp_pkts[k]++;
  endtask

  task automatic monitor(input int d);
    int s;
    int k;
    logic xfer;
    logic [8:0] e;
    xfer = sink_rd[d] & o_vld[d];
    check_eq("udp_rd_without_vld", 32'(udp_rd[d] & ~udp_vld[d]), 0);
    check_eq("icmp_rd_without_vld", 32'(icmp_rd[d] & ~icmp_vld[d]), 0);
    check_eq("both_rd", 32'(udp_rd[d] & icmp_rd[d]), 0);
    if (xfer) begin
      s = int'(o_byte[d][7]);
      k = d * 2 + s;
      check_eq("xfer_pops_source", 32'(s == 1 ? icmp_rd[d] : udp_rd[d]), 1);
      if (cur_src[d] < 0) begin
        start_src[d].push_back(s);
        start_cyc[d].push_back(cyc);
      end else begin
        check_eq("interleave", s, cur_src[d]);
      end
      if (expq[k].size() == 0) begin
        check_eq("extra_byte", expq[k].size(), 1);
      end else begin
        e = expq[k].pop_front();
        check_eq($sformatf("d%0d_s%0d_byte_last", d, s), {o_last[d], o_byte[d]}, e);
      end
      if (o_last[d]) begin
        cur_src[d] = -1;
        end_cyc[d].push_back(cyc);
      end else begin
        cur_src[d] = s;
      end
    end else if (udp_rd[d] || icmp_rd[d]) begin
      check_eq("pop_without_xfer", 32'(o_vld[d]), 0);
      if (udp_rd[d])  got_drain[d * 2]++;
      if (icmp_rd[d]) got_drain[d * 2 + 1]++;
    end
    if (udp_rd[d] && srcq[d * 2].size() > 0) begin
      void'(srcq[d * 2].pop_front());
      pops[d * 2]++;
    end
    if (icmp_rd[d] && srcq[d * 2 + 1].size() > 0) begin
      void'(srcq[d * 2 + 1].pop_front());
      pops[d * 2 + 1]++;
    end
    if (len_err[d]) begin
      err_hi[d]++;
      if (!err_prev[d]) err_pulses[d]++;
    end
    err_prev[d] = len_err[d];
  endtask

  // Drive inputs at the falling edge, sample 1 ns later (well before the rising edge).
  task automatic step();
    logic [8:0] data;
    logic v;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 4; k++) begin
      v    = (srcq[k].size() > 0) && ($urandom_range(99, 0) >= 32'(gap_pct));
      data = (srcq[k].size() > 0) ? srcq[k][0] : 9'h0;
      if (k % 2 == 0) begin
        udp_vld[k / 2]  = v;
        udp_byte[k / 2] = data[7:0];
        udp_last[k / 2] = data[8];
      end else begin
        icmp_vld[k / 2]  = v;
        icmp_byte[k / 2] = data[7:0];
        icmp_last[k / 2] = data[8];
      end
    end
    for (int d = 0; d < 2; d++) sink_rd[d] = ($urandom_range(99, 0) >= 32'(sink_pct));
    #1;
    if (!srst) begin
      monitor(0);
      monitor(1);
    end
  endtask

  task automatic do_reset();
    clear_model();
    srst = 1'b1;
    step();
    srst = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < bound) begin
      step();
      n++;
      done = (cur_src[0] < 0) && (cur_src[1] < 0);
      for (int k = 0; k < 4; k++) done = done && (srcq[k].size() == 0) && (expq[k].size() == 0);
    end
    check_eq({tag, "_completed_in_budget"}, 32'(done), 1);
    step();
    step();
  endtask

  task automatic final_checks(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("%s_d%0d_udp_drain", tag, d), got_drain[d * 2], exp_drain[d * 2]);
      check_eq($sformatf("%s_d%0d_icmp_drain", tag, d), got_drain[d * 2 + 1],
               exp_drain[d * 2 + 1]);
      check_eq($sformatf("%s_d%0d_udp_cnt", tag, d), 32'(udp_cnt[d]),
               32'(exp_pkts[d * 2] & 16'hFFFF));
      check_eq($sformatf("%s_d%0d_icmp_cnt", tag, d), 32'(icmp_cnt[d]),
               32'(exp_pkts[d * 2 + 1] & 16'hFFFF));
      check_eq($sformatf("%s_d%0d_len_err_pulses", tag, d), err_pulses[d], exp_err[d]);
      check_eq($sformatf("%s_d%0d_len_err_hi_cycles", tag, d), err_hi[d], exp_err[d]);
    end
  endtask

  task automatic check_reset_vals(input string tag, input int d);
    check_eq({tag, "_vld"}, 32'(o_vld[d]), 0);
    check_eq({tag, "_last"}, 32'(o_last[d]), 0);
    check_eq({tag, "_byte"}, 32'(o_byte[d]), 0);
    check_eq({tag, "_udp_rd"}, 32'(udp_rd[d]), 0);
    check_eq({tag, "_icmp_rd"}, 32'(icmp_rd[d]), 0);
    check_eq({tag, "_len_err"}, 32'(len_err[d]), 0);
    check_eq({tag, "_udp_cnt"}, 32'(udp_cnt[d]), 0);
    check_eq({tag, "_icmp_cnt"}, 32'(icmp_cnt[d]), 0);
  endtask

  initial begin
    int c0;
    int rr_order [6];
    int sp_order [6];
    int n;
    rr_order = '{0, 1, 0, 1, 0, 1};
    sp_order = '{1, 1, 1, 0, 0, 0};
    n_cmp    = 0;
    n_bad    = 0;
    cyc      = 0;
    gap_pct  = 0;
    sink_pct = 0;
    srst     = 1'b1;
    udp_vld  = '0;
    udp_last = '0;
    icmp_vld = '0;
    icmp_last = '0;
    sink_rd  = '0;
    for (int d = 0; d < 2; d++) begin
      udp_byte[d]  = '0;
      icmp_byte[d] = '0;
    end

    // Reset state
    do_reset();
    step();
    check_reset_vals("por_d0", 0);
    check_reset_vals("por_d1", 1);

    // Single 64-byte UDP packet, sink always ready
    do_reset();
    add_pkt(0, 0, 64);
    c0 = cyc + 1;
    wait_done("single_udp", 300);
    check_eq("single_udp_grant_latency", (start_cyc[0].size() > 0) ? start_cyc[0][0] : -1, c0 + 1);
    check_eq("single_udp_len", (end_cyc[0].size() > 0) ? end_cyc[0][0] - start_cyc[0][0] : -1, 63);
    check_eq("single_udp_pops", pops[0], 64);
    check_eq("single_udp_no_icmp_rd", pops[1], 0);
    final_checks("single_udp");

    // 3 UDP + 3 ICMP packets, both continuously valid
    do_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) begin
        add_pkt(d, 0, int'($urandom_range(16, 4)));
        add_pkt(d, 1, int'($urandom_range(16, 4)));
      end
    end
    wait_done("contend", 500);
    check_eq("contend_rr_pkts", start_src[0].size(), 6);
    check_eq("contend_sp_pkts", start_src[1].size(), 6);
    for (int i = 0; i < 6 && i < start_src[0].size(); i++) begin
      check_eq($sformatf("rr_order_%0d", i), start_src[0][i], rr_order[i]);
      if (i > 0) check_eq($sformatf("rr_gap_%0d", i), start_cyc[0][i] - end_cyc[0][i - 1], 2);
    end
    for (int i = 0; i < 6 && i < start_src[1].size(); i++) begin
      check_eq($sformatf("sp_order_%0d", i), start_src[1][i], sp_order[i]);
      if (i > 0) check_eq($sformatf("sp_gap_%0d", i), start_cyc[1][i] - end_cyc[1][i - 1], 2);
    end
    final_checks("contend");

    // Oversize UDP packet followed by a normal one
    do_reset();
    for (int d = 0; d < 2; d++) begin
      add_pkt(d, 0, 1600);
      add_pkt(d, 0, 10);
    end
    wait_done("trunc", 2500);
    check_eq("trunc_pkts", start_src[0].size(), 2);
    final_checks("trunc");

    // Random gaps on sources and sink over 200 mixed packets
    do_reset();
    gap_pct  = 50;
    sink_pct = 50;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 200; i++) begin
        add_pkt(d, int'($urandom_range(1, 0)),
                (i == 60 || i == 150) ? int'($urandom_range(1520, 1501)) :
                int'($urandom_range(40, 1)));
      end
    end
    wait_done("random", 70000);
    final_checks("random");

    // Reset in the middle of an ICMP packet
    gap_pct  = 0;
    sink_pct = 0;
    do_reset();
    add_pkt(0, 1, 40);
    add_pkt(1, 1, 40);
    n = 0;
    while (expq[1].size() > 20 && n < 200) begin
      step();
      n++;
    end
    check_eq("midpkt_reached_byte20", expq[1].size(), 20);
    do_reset();
    for (int d = 0; d < 2; d++) begin
      add_pkt(d, 0, 8);
      add_pkt(d, 1, 8);
    end
    step();
    check_reset_vals("after_srst_d0", 0);
    check_reset_vals("after_srst_d1", 1);
    wait_done("after_srst", 200);
    check_eq("after_srst_rr_first_udp", (start_src[0].size() > 0) ? start_src[0][0] : -1, 0);
    check_eq("after_srst_sp_first_icmp", (start_src[1].size() > 0) ? start_src[1][0] : -1, 1);
    final_checks("after_srst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
